// File: rtl/axi_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Masters are addressed by a one-bit index throughout the block.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, and on a tie the
// master that did not win last time gets the grant.
module rr_pick2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = M_IFU;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[M_LSU]) begin
      grant = M_LSU;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read slave between the instruction fetch unit (m0) and the
// load/store unit (m1); grant is held from address phase to the last beat.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  input  logic [7:0]        m0_ar_len,
  input  logic [2:0]        m0_ar_size,
  input  logic [3:0]        m0_ar_id,
  output logic              m0_rd_valid,
  input  logic              m0_rd_ready,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic [1:0]        m0_rd_resp,
  output logic              m0_rd_last,
  output logic [3:0]        m0_rd_id,

  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  input  logic [7:0]        m1_ar_len,
  input  logic [2:0]        m1_ar_size,
  input  logic [3:0]        m1_ar_id,
  output logic              m1_rd_valid,
  input  logic              m1_rd_ready,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic [1:0]        m1_rd_resp,
  output logic              m1_rd_last,
  output logic [3:0]        m1_rd_id,

  output logic              s_ar_valid,
  input  logic              s_ar_ready,
  output logic [ADDR_W-1:0] s_ar_addr,
  output logic [7:0]        s_ar_len,
  output logic [2:0]        s_ar_size,
  output logic [3:0]        s_ar_id,
  input  logic              s_rd_valid,
  output logic              s_rd_ready,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic [1:0]        s_rd_resp,
  input  logic              s_rd_last,
  input  logic [3:0]        s_rd_id,

  output logic              err,
  output arb_state_t        state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, ready may depend on valid.
  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] beats_left_q, beats_left_d;
  logic       err_q, err_d;
  logic       pick;

  logic              g_ar_valid;
  logic [ADDR_W-1:0] g_ar_addr;
  logic [7:0]        g_ar_len;
  logic [2:0]        g_ar_size;
  logic [3:0]        g_ar_id;
  logic              g_rd_ready;
  logic              rd_hs;

  rr_pick2 u_pick (
    .req   ({m1_ar_valid, m0_ar_valid}),
    .last  (last_grant_q),
    .grant (pick)
  );

  assign g_ar_valid = (grant_q == M_LSU) ? m1_ar_valid : m0_ar_valid;
  assign g_ar_addr  = (grant_q == M_LSU) ? m1_ar_addr  : m0_ar_addr;
  assign g_ar_len   = (grant_q == M_LSU) ? m1_ar_len   : m0_ar_len;
  assign g_ar_size  = (grant_q == M_LSU) ? m1_ar_size  : m0_ar_size;
  assign g_ar_id    = (grant_q == M_LSU) ? m1_ar_id    : m0_ar_id;
  assign g_rd_ready = (grant_q == M_LSU) ? m1_rd_ready : m0_rd_ready;
  assign rd_hs      = (state_q == DATA) && s_rd_valid && g_rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= M_IFU;
      last_grant_q <= M_LSU;
      beats_left_q <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;

    s_ar_valid  = 1'b0;
    s_ar_addr   = '0;
    s_ar_len    = 8'd0;
    s_ar_size   = 3'd0;
    s_ar_id     = 4'd0;
    s_rd_ready  = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    m0_rd_valid = 1'b0;
    m0_rd_data  = '0;
    m0_rd_resp  = AXI_RESP_OKAY;
    m0_rd_last  = 1'b0;
    m0_rd_id    = 4'd0;
    m1_rd_valid = 1'b0;
    m1_rd_data  = '0;
    m1_rd_resp  = AXI_RESP_OKAY;
    m1_rd_last  = 1'b0;
    m1_rd_id    = 4'd0;

    case (state_q)
      IDLE: begin
        if (m0_ar_valid || m1_ar_valid) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A master that drops valid here simply stalls the address phase.
        s_ar_valid = g_ar_valid;
        s_ar_addr  = g_ar_addr;
        s_ar_len   = g_ar_len;
        s_ar_size  = g_ar_size;
        s_ar_id    = g_ar_id;
        if (grant_q == M_LSU) m1_ar_ready = s_ar_ready;
        else                  m0_ar_ready = s_ar_ready;
        if (g_ar_valid && s_ar_ready) begin
          beats_left_d = g_ar_len;
          state_d      = DATA;
        end
      end
      DATA: begin
        s_rd_ready = g_rd_ready;
        if (grant_q == M_LSU) begin
          m1_rd_valid = s_rd_valid;
          m1_rd_data  = s_rd_data;
          m1_rd_resp  = s_rd_resp;
          m1_rd_last  = s_rd_last;
          m1_rd_id    = s_rd_id;
        end else begin
          m0_rd_valid = s_rd_valid;
          m0_rd_data  = s_rd_data;
          m0_rd_resp  = s_rd_resp;
          m0_rd_last  = s_rd_last;
          m0_rd_id    = s_rd_id;
        end
        if (rd_hs) begin
          if (s_rd_last) begin
            if (beats_left_q != 8'd0) err_d = 1'b1;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else if (beats_left_q == 8'd0) begin
            err_d = 1'b1;
          end else begin
            beats_left_d = beats_left_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset, round-robin, bursts, backpressure,
// length mismatch and reset mid-burst, with hand-computed expectations.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  logic        clk;
  logic        reset;
  logic        m0_ar_valid, m0_ar_ready;
  logic [63:0] m0_ar_addr;
  logic [7:0]  m0_ar_len;
  logic [2:0]  m0_ar_size;
  logic [3:0]  m0_ar_id;
  logic        m0_rd_valid, m0_rd_ready;
  logic [63:0] m0_rd_data;
  logic [1:0]  m0_rd_resp;
  logic        m0_rd_last;
  logic [3:0]  m0_rd_id;
  logic        m1_ar_valid, m1_ar_ready;
  logic [63:0] m1_ar_addr;
  logic [7:0]  m1_ar_len;
  logic [2:0]  m1_ar_size;
  logic [3:0]  m1_ar_id;
  logic        m1_rd_valid, m1_rd_ready;
  logic [63:0] m1_rd_data;
  logic [1:0]  m1_rd_resp;
  logic        m1_rd_last;
  logic [3:0]  m1_rd_id;
  logic        s_ar_valid, s_ar_ready;
  logic [63:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [3:0]  s_ar_id;
  logic        s_rd_valid, s_rd_ready;
  logic [63:0] s_rd_data;
  logic [1:0]  s_rd_resp;
  logic        s_rd_last;
  logic [3:0]  s_rd_id;
  logic        err;
  arb_state_t  state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
    .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_id(m0_ar_id),
    .m0_rd_valid(m0_rd_valid), .m0_rd_ready(m0_rd_ready), .m0_rd_data(m0_rd_data),
    .m0_rd_resp(m0_rd_resp), .m0_rd_last(m0_rd_last), .m0_rd_id(m0_rd_id),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
    .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_id(m1_ar_id),
    .m1_rd_valid(m1_rd_valid), .m1_rd_ready(m1_rd_ready), .m1_rd_data(m1_rd_data),
    .m1_rd_resp(m1_rd_resp), .m1_rd_last(m1_rd_last), .m1_rd_id(m1_rd_id),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_id(s_ar_id),
    .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data),
    .s_rd_resp(s_rd_resp), .s_rd_last(s_rd_last), .s_rd_id(s_rd_id),
    .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic v, input logic [63:0] d, input logic l,
                            input logic [3:0] id);
    s_rd_valid = v;
    s_rd_data  = d;
    s_rd_last  = l;
    s_rd_id    = id;
    s_rd_resp  = AXI_RESP_OKAY;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"},       64'(state), 64'(IDLE));
    chk({tag, "_s_ar_valid"},  64'(s_ar_valid), 64'd0);
    chk({tag, "_s_ar_addr"},   s_ar_addr, 64'd0);
    chk({tag, "_s_ar_len"},    64'(s_ar_len), 64'd0);
    chk({tag, "_s_ar_id"},     64'(s_ar_id), 64'd0);
    chk({tag, "_m0_ar_ready"}, 64'(m0_ar_ready), 64'd0);
    chk({tag, "_m1_ar_ready"}, 64'(m1_ar_ready), 64'd0);
    chk({tag, "_s_rd_ready"},  64'(s_rd_ready), 64'd0);
    chk({tag, "_m0_rd_valid"}, 64'(m0_rd_valid), 64'd0);
    chk({tag, "_m1_rd_valid"}, 64'(m1_rd_valid), 64'd0);
    chk({tag, "_m0_rd_data"},  m0_rd_data, 64'd0);
    chk({tag, "_m1_rd_data"},  m1_rd_data, 64'd0);
    chk({tag, "_m1_rd_last"},  64'(m1_rd_last), 64'd0);
    chk({tag, "_m1_rd_id"},    64'(m1_rd_id), 64'd0);
    chk({tag, "_err"},         64'(err), 64'd0);
  endtask

  initial begin
    int k;
    reset       = 1'b1;
    m0_ar_valid = 1'b1; m0_ar_addr = 64'h1000; m0_ar_len = 8'd0; m0_ar_size = 3'd3; m0_ar_id = 4'd1;
    m1_ar_valid = 1'b1; m1_ar_addr = 64'h2000; m1_ar_len = 8'd0; m1_ar_size = 3'd3; m1_ar_id = 4'd2;
    m0_rd_ready = 1'b1; m1_rd_ready = 1'b1;
    s_ar_ready  = 1'b0;
    drive_beat(1'b0, 64'd0, 1'b0, 4'd0);

    // Reset held three cycles with both masters requesting.
    repeat (3) begin
      cyc(); #1;
      chk_idle("rst");
    end
    reset = 1'b0; #1;
    chk("rel_idle_s_ar_valid", 64'(s_ar_valid), 64'd0);
    cyc(); #1;
    chk("rel_state", 64'(state), 64'(ADDR));
    chk("rel_s_ar_valid", 64'(s_ar_valid), 64'd1);
    chk("rel_s_ar_addr", s_ar_addr, 64'h1000);
    chk("rel_s_ar_id", 64'(s_ar_id), 64'd1);
    chk("rel_m0_ar_ready_lo", 64'(m0_ar_ready), 64'd0);
    s_ar_ready = 1'b1; #1;
    chk("rel_m0_ar_ready", 64'(m0_ar_ready), 64'd1);
    chk("rel_m1_ar_ready", 64'(m1_ar_ready), 64'd0);

    // Round-robin: m0, m1, m0, m1 with one IDLE cycle between transactions.
    cyc(); m0_ar_valid = 1'b0; drive_beat(1'b1, 64'hAAAA, 1'b1, 4'd1); #1;
    chk("rr0_state", 64'(state), 64'(DATA));
    chk("rr0_m0_rd_valid", 64'(m0_rd_valid), 64'd1);
    chk("rr0_m0_rd_data", m0_rd_data, 64'hAAAA);
    chk("rr0_m0_rd_last", 64'(m0_rd_last), 64'd1);
    chk("rr0_m0_rd_id", 64'(m0_rd_id), 64'd1);
    chk("rr0_m1_rd_valid", 64'(m1_rd_valid), 64'd0);
    chk("rr0_m1_rd_data", m1_rd_data, 64'd0);
    chk("rr0_s_rd_ready", 64'(s_rd_ready), 64'd1);
    cyc(); drive_beat(1'b0, 64'd0, 1'b0, 4'd0); m0_ar_valid = 1'b1; #1;
    chk("rr0_gap_state", 64'(state), 64'(IDLE));
    cyc(); #1;
    chk("rr1_s_ar_addr", s_ar_addr, 64'h2000);
    chk("rr1_m1_ar_ready", 64'(m1_ar_ready), 64'd1);
    chk("rr1_m0_ar_ready", 64'(m0_ar_ready), 64'd0);
    cyc(); drive_beat(1'b1, 64'hBBBB, 1'b1, 4'd2); #1;
    chk("rr1_m1_rd_data", m1_rd_data, 64'hBBBB);
    chk("rr1_m0_rd_valid", 64'(m0_rd_valid), 64'd0);
    cyc(); drive_beat(1'b0, 64'd0, 1'b0, 4'd0); #1;
    chk("rr1_gap_state", 64'(state), 64'(IDLE));
    cyc(); #1;
    chk("rr2_s_ar_addr", s_ar_addr, 64'h1000);
    cyc(); drive_beat(1'b1, 64'hCCCC, 1'b1, 4'd1); #1;
    chk("rr2_m0_rd_data", m0_rd_data, 64'hCCCC);
    cyc(); drive_beat(1'b0, 64'd0, 1'b0, 4'd0); m0_ar_valid = 1'b0; #1;
    chk("rr2_gap_state", 64'(state), 64'(IDLE));
    cyc(); #1;
    chk("rr3_s_ar_valid", 64'(s_ar_valid), 64'd1);
    chk("rr3_s_ar_addr", s_ar_addr, 64'h2000);
    cyc(); m1_ar_valid = 1'b0; drive_beat(1'b1, 64'hDDDD, 1'b1, 4'd2); #1;
    chk("rr3_m1_rd_data", m1_rd_data, 64'hDDDD);
    cyc(); drive_beat(1'b0, 64'd0, 1'b0, 4'd0); #1;
    chk("rr3_gap_state", 64'(state), 64'(IDLE));

    // Single-master 4-beat burst from m1.
    m1_ar_valid = 1'b1; m1_ar_addr = 64'h8000_0040; m1_ar_len = 8'd3; m1_ar_id = 4'd5; #1;
    chk("sb_idle_s_ar_valid", 64'(s_ar_valid), 64'd0);
    cyc(); #1;
    chk("sb_s_ar_valid", 64'(s_ar_valid), 64'd1);
    chk("sb_s_ar_addr", s_ar_addr, 64'h8000_0040);
    chk("sb_s_ar_len", 64'(s_ar_len), 64'd3);
    cyc(); m1_ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, 64'h100 + 64'(i), (i == 3), 4'd5); #1;
      chk("sb_m1_rd_valid", 64'(m1_rd_valid), 64'd1);
      chk("sb_m1_rd_data", m1_rd_data, 64'h100 + 64'(i));
      chk("sb_m1_rd_last", 64'(m1_rd_last), 64'(i == 3));
      chk("sb_m0_rd_valid", 64'(m0_rd_valid), 64'd0);
      chk("sb_err", 64'(err), 64'd0);
      cyc();
    end
    drive_beat(1'b0, 64'd0, 1'b0, 4'd0); #1;
    chk("sb_end_state", 64'(state), 64'(IDLE));
    chk("sb_end_err", 64'(err), 64'd0);

    // Backpressure on a 4-beat m0 burst.
    m0_ar_valid = 1'b1; m0_ar_addr = 64'h3000; m0_ar_len = 8'd3; m0_ar_id = 4'd3;
    for (int i = 0; i < 4; i++) exp_q.push_back(64'd200 + 64'(i));
    cyc(); #1;
    chk("bp_state", 64'(state), 64'(ADDR));
    chk("bp_s_ar_len", 64'(s_ar_len), 64'd3);
    cyc(); m0_ar_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 8 && k < 4; c++) begin
      m0_rd_ready = pat[c];
      drive_beat(1'b1, 64'd200 + 64'(k), (k == 3), 4'd3); #1;
      chk("bp_s_rd_ready", 64'(s_rd_ready), 64'(pat[c]));
      if (m0_rd_valid && m0_rd_ready) got_q.push_back(m0_rd_data);
      if (s_rd_valid && s_rd_ready) k++;
      cyc();
    end
    drive_beat(1'b0, 64'd0, 1'b0, 4'd0); m0_rd_ready = 1'b1; #1;
    chk("bp_beats_sent", 64'(k), 64'd4);
    chk("bp_beats_recv", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_order", got_q[i], exp_q[i]);
    chk("bp_end_state", 64'(state), 64'(IDLE));
    chk("bp_err", 64'(err), 64'd0);

    // Length mismatch: len 3 but last arrives on beat 2.
    m1_ar_valid = 1'b1; m1_ar_addr = 64'h4000; m1_ar_len = 8'd3; m1_ar_id = 4'd6;
    cyc();
    cyc(); m1_ar_valid = 1'b0; drive_beat(1'b1, 64'h400, 1'b0, 4'd6); #1;
    chk("lm_b0_err", 64'(err), 64'd0);
    cyc(); drive_beat(1'b1, 64'h401, 1'b1, 4'd6); #1;
    chk("lm_b1_err", 64'(err), 64'd0);
    chk("lm_b1_last", 64'(m1_rd_last), 64'd1);
    cyc(); drive_beat(1'b0, 64'd0, 1'b0, 4'd0); #1;
    chk("lm_err_set", 64'(err), 64'd1);
    chk("lm_state", 64'(state), 64'(IDLE));
    cyc(); #1;
    chk("lm_err_sticky", 64'(err), 64'd1);

    // Reset after beat 1 of an m1 len-7 burst.
    m1_ar_valid = 1'b1; m1_ar_addr = 64'h5000; m1_ar_len = 8'd7; m1_ar_id = 4'd7;
    cyc();
    cyc(); m1_ar_valid = 1'b0; drive_beat(1'b1, 64'h500, 1'b0, 4'd7); #1;
    chk("mr_b0_valid", 64'(m1_rd_valid), 64'd1);
    cyc(); reset = 1'b1; drive_beat(1'b1, 64'h501, 1'b0, 4'd7);
    cyc(); #1;
    chk_idle("mr");
    drive_beat(1'b0, 64'd0, 1'b0, 4'd0); reset = 1'b0;
    m0_ar_valid = 1'b1; m0_ar_addr = 64'h6000; m0_ar_len = 8'd0; m0_ar_id = 4'd8;
    cyc(); #1;
    chk("mr_new_state", 64'(state), 64'(ADDR));
    chk("mr_new_addr", s_ar_addr, 64'h6000);
    cyc(); m0_ar_valid = 1'b0; drive_beat(1'b1, 64'h600, 1'b1, 4'd8); #1;
    chk("mr_new_data", m0_rd_data, 64'h600);
    chk("mr_new_id", 64'(m0_rd_id), 64'd8);
    cyc(); drive_beat(1'b0, 64'd0, 1'b0, 4'd0); #1;
    chk("mr_end_state", 64'(state), 64'(IDLE));
    chk("mr_end_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master read-channel arbiter that shares the single AXI-style memory slave (`SRAM_AXI`) between the instruction fetch unit (master 0) and the load/store unit (master 1). It grants one master at a time, forwards that master's read address to the slave, and steers the returning data beats, including multi-beat bursts, back to the granted master. Grant is held until the final beat. Writes bypass this block; the LSU drives the slave write channels directly.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `clk`  in  1: clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `m{0,1}_ar_valid`  in  1: read request from master n.
- `m{0,1}_ar_ready`  out  1: master n's read address is accepted.
- `m{0,1}_ar_addr`  in  ADDR_W: read address.
- `m{0,1}_ar_len`  in  8: burst length; beats = len+1.
- `m{0,1}_ar_size`  in  3: bytes per beat, log2.
- `m{0,1}_ar_id`  in  4: transaction ID.
- `m{0,1}_rd_valid`  out  1: read data beat valid toward master n.
- `m{0,1}_rd_ready`  in  1: master n accepts the beat.
- `m{0,1}_rd_data`  out  DATA_W: beat data.
- `m{0,1}_rd_resp`  out  2: response code.
- `m{0,1}_rd_last`  out  1: final beat.
- `m{0,1}_rd_id`  out  4: ID echo.
- `s_ar_valid`, `s_ar_addr`, `s_ar_len`, `s_ar_size`, `s_ar_id`  out: slave address channel, same widths as the master address channel.
- `s_ar_ready`  in  1: slave accepts the address.
- `s_rd_valid`, `s_rd_data`, `s_rd_resp`, `s_rd_last`, `s_rd_id`  in: slave data channel, same widths as the master data channel.
- `s_rd_ready`  out  1: arbiter accepts the slave beat.
- `err`  out  1: sticky burst-length mismatch flag.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `m*_ar_valid` is high, register `grant` and go to ADDR.
  - Round-robin: a lone requester wins. If both request, the master that is not `last_grant` wins.
- ADDR:
  - `s_ar_*` is driven combinationally from the granted master's `ar_*`.
  - `m[grant]_ar_ready` equals `s_ar_ready`.
  - On `s_ar_valid && s_ar_ready`, load `beats_left = ar_len` and go to DATA.
- DATA:
  - `m[grant]_rd_*` mirrors `s_rd_*`, and `s_rd_ready` equals `m[grant]_rd_ready`.
  - Each handshake with `!s_rd_last` decrements `beats_left`.
  - A handshake with `s_rd_last` sets `last_grant = grant` and returns to IDLE.
- The non-granted master always sees `ar_ready=0` and `rd_valid=0`; its `rd_data`, `rd_resp`, `rd_id` and `rd_last` are 0.
- `err` is set when either of these occurs; only reset clears it:
  - `s_rd_last` arrives with `beats_left != 0`.
  - A non-last beat arrives with `beats_left == 0`; the count saturates at 0 and does not wrap.
- A master that drops `ar_valid` while in ADDR has a protocol error. The FSM stays in ADDR with `s_ar_valid=0` until that master reasserts.

## Timing
- Reset: state IDLE, `grant=0`, `last_grant=1` (so master 0 wins the first tie), `beats_left=0`, `err=0`. All `*_valid`/`*_ready` outputs are 0 and all data outputs are 0.
- Arbitration latency is 1 cycle. A request seen in IDLE at cycle N is presented on `s_ar_valid` at N+1.
- Address and data paths are combinational pass-through, with no added beat latency.
- Back-to-back transactions: after the last beat, the FSM spends one IDLE cycle before the next ADDR. Minimum gap is 1 cycle.
- Reset asserted mid-burst: return to IDLE next edge. In-flight beats are dropped; the slave shares the reset.
- Simultaneous new request and last beat: the new request is not sampled until IDLE.

## Structure
- Shared package `axi_pkg` holds:
  - the `arb_state_t` enum (IDLE/ADDR/DATA);
  - `AXI_RESP_OKAY = 2'b00`;
  - master index constants `M_IFU = 0` and `M_LSU = 1`.
- One sub-module, `rr_pick2`: combinational 2-way round-robin selector with inputs (req[1:0], last) and output grant.
- The muxing stays in the top module.

## Test plan
- **Reset values:** hold reset 3 cycles with both masters requesting → all outputs 0, `err=0`. On release, `s_ar_valid` rises one cycle later with `s_ar_addr` from m0.
- **Single-master burst:** m1 alone requests addr `0x8000_0040`, len 3 → slave sees that addr and len 3. m1 receives 4 beats, `rd_last` only on beat 4. m0 sees `rd_valid=0` throughout; `err=0`.
- **Round-robin fairness:** both masters request continuously, len 0 → grants alternate m0, m1, m0, m1. Each transaction is separated by exactly one IDLE cycle.
- **Backpressure:** during a 4-beat m0 burst, `m0_rd_ready` toggles low → `s_rd_ready` follows. No beat is lost or duplicated, and the data order is preserved.
- **Length mismatch:** request len 3, slave asserts `rd_last` on beat 2 → `err` rises at the next edge and stays high. The FSM returns to IDLE.
- **Reset mid-burst:** assert reset after beat 1 of an m1 len-7 burst → next cycle state is IDLE and all outputs are 0. After release, a fresh m0 request proceeds normally.
